dcache_responder: RTL

DCACHE_RESPONDER -- requirements
Module: dcache_responder

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_array.sv | 58 +++++
 rtl/dcache_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, write-through data cache responder.
package dcache_pkg;

  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  // Address split: tag = [31:8], index = [7:4], word offset = [3:2].
  localparam int TAG_W = 24;
  localparam int IDX_W = 4;
  localparam int OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    REFILL_REQ = 2'd2,
    REFILL     = 2'd3
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the cache: one combinational lookup port, a
// byte-masked word write port and a line-word refill port sharing the line index.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [OFF_W-1:0] off_i,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic             rd_valid_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_mask_i,
  input  logic [31:0]      wr_data_i,
  input  logic             fill_en_i,
  input  logic [OFF_W-1:0] fill_off_i,
  input  logic [31:0]      fill_data_i,
  input  logic             inval_en_i,
  input  logic             set_en_i,
  input  logic [TAG_W-1:0] set_tag_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS_PER_LINE];

  assign rd_tag_o   = tag_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_data_o  = data_q[idx_i][off_i];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (set_en_i) begin
      valid_q[idx_i] <= 1'b1;
    end else if (inval_en_i) begin
      valid_q[idx_i] <= 1'b0;
    end
  end

  // NOTE: tag and data arrays carry no reset; a line is only trusted once its
  // valid bit is set, so resetting the RAM contents would buy nothing.
  always_ff @(posedge clk) begin
    if (set_en_i) tag_q[idx_i] <= set_tag_i;
    if (fill_en_i) begin
      data_q[idx_i][fill_off_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[idx_i][off_i] <= byte_merge(data_q[idx_i][off_i], wr_data_i, wr_mask_i);
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache with a single
// outstanding backing-memory request (line refill or word write).
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  state_e           state_q, state_d;
  logic [31:2]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic [3:0]       mask_q, mask_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dout_q, dout_d;
  logic             stall_q;

  logic [31:2]      lk_addr;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             hit;
  logic             wr_en, fill_en, inval_en, set_en;

  // Byte-offset bits never influence the cache; they are dropped here on purpose.
  logic [1:0] unused_addr_bits;
  assign unused_addr_bits = dcache_addr[1:0];

  // In IDLE the core's live address is looked up; otherwise the captured one.
  assign lk_addr = (state_q == IDLE) ? dcache_addr[31:2] : addr_q;
  assign hit     = rd_valid && (rd_tag == lk_addr[31:8]);

  dcache_array #(
    .LINES         (LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_array (
    .clk        (clk),
    .rst_n      (reset),
    .idx_i      (lk_addr[7:4]),
    .off_i      (lk_addr[3:2]),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_mask_i  (dcache_we),
    .wr_data_i  (dcache_din),
    .fill_en_i  (fill_en),
    .fill_off_i (cnt_q),
    .fill_data_i(mem_resp_data),
    .inval_en_i (inval_en),
    .set_en_i   (set_en),
    .set_tag_i  (addr_q[31:8])
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    din_d         = din_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    dout_d        = dout_q;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    inval_en      = 1'b0;
    set_en        = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = '0;

    unique case (state_q)
      IDLE: begin
        if (dcache_we != 4'b0000) begin
          addr_d  = dcache_addr[31:2];
          din_d   = dcache_din;
          mask_d  = dcache_we;
          wr_en   = hit;
          state_d = WRITE;
        end else if (dcache_re) begin
          addr_d = dcache_addr[31:2];
          if (hit) begin
            dout_d = rd_data;
          end else begin
            inval_en = 1'b1;
            state_d  = REFILL_REQ;
          end
        end
      end

      WRITE: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {addr_q[31:2], 2'b00};
        mem_req_data  = din_q;
        mem_req_mask  = mask_q;
        if (mem_req_ready) state_d = IDLE;
      end

      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[31:4], 4'b0000};
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end

      REFILL: begin
        if (mem_resp_valid) begin
          fill_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            set_en  = 1'b1;
            // The requested word is either arriving now or already in the array.
            dout_d  = (addr_q[3:2] == cnt_q) ? mem_resp_data : rd_data;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      stall_q <= (state_d != IDLE);
    end
  end

  assign stall       = stall_q;
  assign dcache_dout = dout_q;

endmodule
